ibex_rf_wport_arbiter: RTL

Shares the single register-file write port between the core's writeback result (writeback-stage output, already merged from ID/EX and LSU load data) and a background capability-maintenance requester, e.g. a revocation/tag-clear sweeper. Core writes always win and are never delayed. Background writes use idle port cycles, with a starvation counter that requests a core stall. A background write is killed if the core overwrites the same register while it is pending. The block sits between `ibex_wb_stage` and the register file.

---
 rtl/ibex_rf_wport_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ibex_rf_wport_arbiter.sv
// Shares the register-file write port between core writeback (always wins) and a
// background capability-maintenance requester, which uses idle cycles and may request a stall.
module ibex_rf_wport_arbiter #(
    parameter int unsigned CheriCapWidth = 91,
    parameter int unsigned StarveLimit   = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,

    input  logic                     core_we_i,
    input  logic [4:0]               core_waddr_i,
    input  logic [31:0]              core_wdata_int_i,
    input  logic [CheriCapWidth-1:0] core_wdata_cap_i,
    input  logic                     core_wcap_i,

    input  logic                     bg_req_i,
    input  logic [4:0]               bg_waddr_i,
    input  logic [31:0]              bg_wdata_int_i,
    input  logic [CheriCapWidth-1:0] bg_wdata_cap_i,
    input  logic                     bg_wcap_i,
    output logic                     bg_ready_o,
    output logic                     bg_done_o,
    output logic                     bg_killed_o,

    output logic                     stall_core_o,
    output logic                     busy_o,

    output logic                     rf_we_o,
    output logic [4:0]               rf_waddr_o,
    output logic [31:0]              rf_wdata_int_o,
    output logic [CheriCapWidth-1:0] rf_wdata_cap_o,
    output logic                     rf_wcap_o
);

    localparam logic [3:0] StarveLim = 4'(StarveLimit);

    logic                     pend_q;
    logic [4:0]               pend_waddr_q;
    logic [31:0]              pend_wdata_int_q;
    logic [CheriCapWidth-1:0] pend_wdata_cap_q;
    logic                     pend_wcap_q;
    logic [3:0]               wait_cnt_q;
    logic [3:0]               wait_cnt_d;

    logic accept;
    logic pend_nz;
    logic kill;
    logic bg_drive;
    logic done;

    assign accept   = bg_req_i & ~pend_q;
    assign pend_nz  = (pend_waddr_q != 5'd0);
    // Core overwriting the pending destination makes the background value stale.
    assign kill     = pend_q & core_we_i & pend_nz & (core_waddr_i == pend_waddr_q);
    assign bg_drive = pend_q & ~core_we_i & pend_nz;
    assign done     = (pend_q & ~core_we_i) | kill;

    assign bg_ready_o   = ~pend_q;
    assign busy_o       = pend_q;
    assign bg_done_o    = done;
    assign bg_killed_o  = kill;
    assign stall_core_o = pend_q & (wait_cnt_q == StarveLim);

    always_comb begin
        rf_we_o        = 1'b0;
        rf_waddr_o     = 5'd0;
        rf_wdata_int_o = 32'd0;
        rf_wdata_cap_o = '0;
        rf_wcap_o      = 1'b0;
        if (core_we_i) begin
            rf_we_o        = 1'b1;
            rf_waddr_o     = core_waddr_i;
            rf_wdata_int_o = core_wdata_int_i;
            rf_wdata_cap_o = core_wdata_cap_i;
            rf_wcap_o      = core_wcap_i;
        end else if (bg_drive) begin
            rf_we_o        = 1'b1;
            rf_waddr_o     = pend_waddr_q;
            rf_wdata_int_o = pend_wdata_int_q;
            rf_wdata_cap_o = pend_wdata_cap_q;
            rf_wcap_o      = pend_wcap_q;
        end
    end

    // Count only cycles the core actually blocked us; saturate so the stall holds until done.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (accept || done) begin
            wait_cnt_d = 4'd0;
        end else if (pend_q && core_we_i && (wait_cnt_q < StarveLim)) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q           <= 1'b0;
            pend_waddr_q     <= 5'd0;
            pend_wdata_int_q <= 32'd0;
            pend_wdata_cap_q <= '0;
            pend_wcap_q      <= 1'b0;
            wait_cnt_q       <= 4'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            if (accept) begin
                pend_q           <= 1'b1;
                pend_waddr_q     <= bg_waddr_i;
                pend_wdata_int_q <= bg_wdata_int_i;
                pend_wdata_cap_q <= bg_wdata_cap_i;
                pend_wcap_q      <= bg_wcap_i;
            end else if (done) begin
                pend_q <= 1'b0;
            end
        end
    end

    one_write_source : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(core_we_i && bg_drive) && (rf_we_o == (core_we_i || bg_drive)));

    killed_implies_done : assert property (@(posedge clk_i) disable iff (!rst_ni)
        bg_killed_o |-> bg_done_o);

endmodule
